// File: rtl/fft_twiddle_seq_if.sv
// Sample/twiddle stream bundle for fft_twiddle_seq: upstream butterfly samples in,
// samples with aligned twiddle coefficients and frame flags out.
interface fft_twiddle_seq_if #(
   parameter int NBITS      = 16,
   parameter int NBITScoeff = 16
);
   logic                    in_valid;
   logic                    in_sof;
   logic [2*NBITS-1:0]      in_muestra;
   logic                    out_valid;
   logic [2*NBITS-1:0]      out_muestra;
   logic [2*NBITScoeff-1:0] out_coeff;
   logic                    out_sof;
   logic                    out_eof;
   logic                    frame_err;

   modport master (
      output in_valid, in_sof, in_muestra,
      input  out_valid, out_muestra, out_coeff, out_sof, out_eof, frame_err
   );

   modport slave (
      input  in_valid, in_sof, in_muestra,
      output out_valid, out_muestra, out_coeff, out_sof, out_eof, frame_err
   );
endinterface

// File: rtl/fft_twiddle_seq.sv
// Twiddle sequencer for one radix-2 DIF SDF stage: indexes each sample in its frame and
// pairs it with W^e from an elaboration-time ROM, 2-cycle latency. FFT_TWIDDLE_CONJ_EN selects conjugate (IFFT) twiddles.
module fft_twiddle_seq #(
   parameter int NBITS      = 16,
   parameter int NBITScoeff = 16,
   parameter int N          = 128,
   parameter int STAGE      = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   fft_twiddle_seq_if.slave bus
);
   localparam int CW   = $clog2(N);
   localparam int EW   = (CW > 1) ? CW - 1 : 1;
   localparam int HALF = (N >> STAGE) / 2;
   localparam logic [CW-1:0] PMASK  = CW'((N >> STAGE) - 1);
   localparam logic [CW-1:0] HALF_C = CW'(HALF);
   localparam logic [CW-1:0] LAST   = CW'(N - 1);
   localparam real PI  = 3.14159265358979323846;
   localparam real AMP = 2.0 ** (NBITScoeff - 1) - 1.0;

   // Coefficient ROM, real in the upper half, imag in the lower half
   logic [2*NBITScoeff-1:0] rom [N/2];

   for (genvar gi = 0; gi < N / 2; gi++) begin : g_rom
      localparam real ANG = 2.0 * PI * real'(gi) / real'(N);
      localparam real XR  = AMP * $cos(ANG);
`ifdef FFT_TWIDDLE_CONJ_EN
      localparam real XI  = AMP * $sin(ANG);
`else
      localparam real XI  = -AMP * $sin(ANG);
`endif
      localparam int CR = (XR >= 0.0) ? $rtoi(XR + 0.5) : -$rtoi(0.5 - XR);
      localparam int CI = (XI >= 0.0) ? $rtoi(XI + 0.5) : -$rtoi(0.5 - XI);
      assign rom[gi] = {NBITScoeff'(CR), NBITScoeff'(CI)};
   end

   logic [CW-1:0]           cnt_reg;
   logic                    s1_valid_reg;
   logic                    s1_sof_reg;
   logic                    s1_eof_reg;
   logic                    s1_err_reg;
   logic [2*NBITS-1:0]      s1_muestra_reg;
   logic [EW-1:0]           s1_e_reg;
   logic                    valid_reg;
   logic                    sof_reg;
   logic                    eof_reg;
   logic                    err_reg;
   logic [2*NBITS-1:0]      muestra_reg;
   logic [2*NBITScoeff-1:0] coeff_reg;

   logic [CW-1:0] idx_next;
   logic [CW-1:0] p_next;
   logic [EW-1:0] e_next;
   logic          err_next;

   // Upper half of each DIF sub-block of length N>>STAGE gets a nontrivial twiddle
   always_comb begin
      idx_next = bus.in_sof ? '0 : cnt_reg;
      p_next   = idx_next & PMASK;
      e_next   = '0;
      if (p_next >= HALF_C) begin
         e_next = EW'((p_next - HALF_C) << STAGE);
      end
      err_next = bus.in_sof && (cnt_reg != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg        <= '0;
         s1_valid_reg   <= 1'b0;
         s1_sof_reg     <= 1'b0;
         s1_eof_reg     <= 1'b0;
         s1_err_reg     <= 1'b0;
         s1_muestra_reg <= '0;
         s1_e_reg       <= '0;
         valid_reg      <= 1'b0;
         sof_reg        <= 1'b0;
         eof_reg        <= 1'b0;
         err_reg        <= 1'b0;
         muestra_reg    <= '0;
         coeff_reg      <= '0;
      end else begin
         s1_valid_reg <= bus.in_valid;
         if (bus.in_valid) begin
            cnt_reg        <= idx_next + CW'(1);
            s1_sof_reg     <= bus.in_sof;
            s1_eof_reg     <= (idx_next == LAST);
            s1_err_reg     <= err_next;
            s1_muestra_reg <= bus.in_muestra;
            s1_e_reg       <= e_next;
         end
         valid_reg <= s1_valid_reg;
         err_reg   <= s1_valid_reg & s1_err_reg;
         if (s1_valid_reg) begin
            sof_reg     <= s1_sof_reg;
            eof_reg     <= s1_eof_reg;
            muestra_reg <= s1_muestra_reg;
            coeff_reg   <= rom[s1_e_reg];
         end
      end
   end

   assign bus.out_valid   = valid_reg;
   assign bus.out_sof     = sof_reg;
   assign bus.out_eof     = eof_reg;
   assign bus.frame_err   = err_reg;
   assign bus.out_muestra = muestra_reg;
   assign bus.out_coeff   = coeff_reg;
endmodule

// File: tb/tb_fft_twiddle_seq.sv
// Randomized bench for fft_twiddle_seq: STAGE=0 and STAGE=1 instances share one stimulus
// stream and are checked against an arithmetic model of frame indexing and twiddle values.
module tb_fft_twiddle_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fft_twiddle_seq_if #(.NBITS(16), .NBITScoeff(16)) bus0 ();
   fft_twiddle_seq_if #(.NBITS(16), .NBITScoeff(16)) bus1 ();

   fft_twiddle_seq #(.NBITS(16), .NBITScoeff(16), .N(128), .STAGE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
   fft_twiddle_seq #(.NBITS(16), .NBITScoeff(16), .N(128), .STAGE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

`ifdef FFT_TWIDDLE_CONJ_EN
   localparam logic [31:0] C_E32 = 32'h0000_7FFF;
   localparam logic [31:0] C_E16 = 32'h5A82_5A82;
`else
   localparam logic [31:0] C_E32 = 32'h0000_8001;
   localparam logic [31:0] C_E16 = 32'h5A82_A57E;
`endif
   localparam logic [31:0] C_ONE = 32'h7FFF_0000;

   typedef struct packed {
      logic        v;
      logic        sof;
      logic        eof;
      logic        err;
      logic [6:0]  idx;
      logic [31:0] d;
      logic [31:0] c0;
      logic [31:0] c1;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   int   m_cnt  = 0;
   exp_t pend   = '0;

   function automatic logic [31:0] twiddle(int idx, int stage);
      int  l, p, e, cr, ci;
      real ang, xr, xi;
      l   = 128 >> stage;
      p   = idx % l;
      e   = (p < l / 2) ? 0 : (p - l / 2) * (1 << stage);
      ang = 2.0 * 3.141592653589793 * e / 128.0;
      xr  = 32767.0 * $cos(ang);
`ifdef FFT_TWIDDLE_CONJ_EN
      xi  = 32767.0 * $sin(ang);
`else
      xi  = -32767.0 * $sin(ang);
`endif
      cr  = (xr >= 0.0) ? $rtoi(xr + 0.5) : -$rtoi(0.5 - xr);
      ci  = (xi >= 0.0) ? $rtoi(xi + 0.5) : -$rtoi(0.5 - xi);
      return {cr[15:0], ci[15:0]};
   endfunction

   function automatic logic [101:0] got_vec();
      return {bus0.out_valid, bus1.out_valid, bus0.frame_err, bus1.frame_err,
              bus0.out_sof, bus0.out_eof, bus0.out_muestra, bus0.out_coeff, bus1.out_coeff};
   endfunction

   function automatic logic [101:0] want_vec(exp_t ex);
      return {ex.v, ex.v, ex.v & ex.err, ex.v & ex.err, ex.sof, ex.eof, ex.d, ex.c0, ex.c1};
   endfunction

   // Payload fields are don't-care while no sample is being emitted
   function automatic logic [101:0] mask_vec(exp_t ex);
      return ex.v ? {102{1'b1}} : {4'hF, 98'd0};
   endfunction

   task automatic model_reset();
      m_cnt = 0;
      pend  = '0;
   endtask

   task automatic step(input logic v, input logic sof, input logic [31:0] d, output exp_t ex);
      exp_t cur;
      int   idx;
      cur = '0;
      bus0.in_valid = v; bus0.in_sof = sof; bus0.in_muestra = d;
      bus1.in_valid = v; bus1.in_sof = sof; bus1.in_muestra = d;
      if (v) begin
         idx     = sof ? 0 : m_cnt;
         cur.v   = 1'b1;
         cur.sof = sof;
         cur.err = sof && (m_cnt != 0);
         cur.eof = (idx == 127);
         cur.idx = 7'(idx);
         cur.d   = d;
         cur.c0  = twiddle(idx, 0);
         cur.c1  = twiddle(idx, 1);
         m_cnt   = (idx + 1) % 128;
      end
      @(posedge clk);
      #1;
      ex   = pend;
      pend = cur;
   endtask

   task automatic test_reset();
      bus0.in_valid = 1'b0; bus0.in_sof = 1'b0; bus0.in_muestra = '0;
      bus1.in_valid = 1'b0; bus1.in_sof = 1'b0; bus1.in_muestra = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      if (got_vec() !== 102'd0) begin
         errors++;
         $display("FAIL reset_state got=%h want=0", got_vec());
      end
      checks++;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_stage_sweep();
      exp_t ex;
      for (int i = 0; i < 130; i++) begin
         step(i < 128, i == 0, $urandom, ex);
         if ((got_vec() & mask_vec(ex)) !== (want_vec(ex) & mask_vec(ex))) begin
            errors++;
            $display("FAIL sweep idx=%0d got=%h want=%h", ex.idx, got_vec(), want_vec(ex));
         end
         checks++;
         if (ex.v) begin
            if (ex.idx <= 7'd64 && bus0.out_coeff !== C_ONE) begin
               errors++;
               $display("FAIL s0_unity idx=%0d got=%h want=%h", ex.idx, bus0.out_coeff, C_ONE);
            end
            if (ex.idx == 7'd80 && bus0.out_coeff !== C_E16) begin
               errors++;
               $display("FAIL s0_idx80 got=%h want=%h", bus0.out_coeff, C_E16);
            end
            if (ex.idx == 7'd96 && bus0.out_coeff !== C_E32) begin
               errors++;
               $display("FAIL s0_idx96 got=%h want=%h", bus0.out_coeff, C_E32);
            end
            if ((ex.idx == 7'd32 || ex.idx == 7'd96) && bus1.out_coeff !== C_ONE) begin
               errors++;
               $display("FAIL s1_unity idx=%0d got=%h want=%h", ex.idx, bus1.out_coeff, C_ONE);
            end
            if ((ex.idx == 7'd48 || ex.idx == 7'd112) && bus1.out_coeff !== C_E32) begin
               errors++;
               $display("FAIL s1_e32 idx=%0d got=%h want=%h", ex.idx, bus1.out_coeff, C_E32);
            end
            checks++;
         end
      end
   endtask

   task automatic test_bubbles();
      exp_t ex;
      logic v, sof;
      for (int i = 0; i < 320; i++) begin
         v   = ($urandom_range(0, 99) < 65);
         sof = v ? (m_cnt == 0) : 1'($urandom_range(0, 1));
         step(v, sof, $urandom, ex);
         if ((got_vec() & mask_vec(ex)) !== (want_vec(ex) & mask_vec(ex))) begin
            errors++;
            $display("FAIL bubbles step=%0d idx=%0d got=%h want=%h", i, ex.idx, got_vec(), want_vec(ex));
         end
         checks++;
      end
   endtask

   task automatic test_frame_err();
      exp_t ex;
      for (int i = 0; i < 60; i++) begin
         step(1'b1, (i == 0) || (i == 50), $urandom, ex);
         if ((got_vec() & mask_vec(ex)) !== (want_vec(ex) & mask_vec(ex))) begin
            errors++;
            $display("FAIL frame_err_stream idx=%0d got=%h want=%h", ex.idx, got_vec(), want_vec(ex));
         end
         checks++;
         if (i == 51) begin
            if ({bus0.out_valid, bus0.out_sof, bus0.frame_err, bus1.frame_err} !== 4'hF) begin
               errors++;
               $display("FAIL frame_err_pulse got=%b want=1111",
                        {bus0.out_valid, bus0.out_sof, bus0.frame_err, bus1.frame_err});
            end
            checks++;
         end
         if (i == 52) begin
            if ({bus0.frame_err, bus0.out_coeff} !== {1'b0, C_ONE}) begin
               errors++;
               $display("FAIL frame_err_restart got=%h want=%h", {bus0.frame_err, bus0.out_coeff}, {1'b0, C_ONE});
            end
            checks++;
         end
      end
   endtask

   task automatic test_reset_midframe();
      exp_t ex;
      for (int i = 0; i <= 70; i++) begin
         step(1'b1, i == 0, $urandom, ex);
         if ((got_vec() & mask_vec(ex)) !== (want_vec(ex) & mask_vec(ex))) begin
            errors++;
            $display("FAIL pre_reset idx=%0d got=%h want=%h", ex.idx, got_vec(), want_vec(ex));
         end
         checks++;
      end
      rst_n = 1'b0;
      #1;
      if (got_vec() !== 102'd0) begin
         errors++;
         $display("FAIL midframe_reset_clear got=%h want=0", got_vec());
      end
      checks++;
      bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 140; i++) begin
         step(1'b1, 1'b0, $urandom, ex);
         if ((got_vec() & mask_vec(ex)) !== (want_vec(ex) & mask_vec(ex))) begin
            errors++;
            $display("FAIL post_reset idx=%0d got=%h want=%h", ex.idx, got_vec(), want_vec(ex));
         end
         checks++;
         if (i == 1 && bus0.out_coeff !== C_ONE) begin
            errors++;
            $display("FAIL post_reset_idx0 got=%h want=%h", bus0.out_coeff, C_ONE);
         end
      end
   endtask

   initial begin
      test_reset();
      test_stage_sweep();
      test_bubbles();
      test_frame_err();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fft_twiddle_seq.md
Name: fft_twiddle_seq

Overview:
- Per-sample twiddle sequencer for one radix-2 DIF SDF stage of the N=128 FFT.
- Sits directly upstream of the complex multiplier. It takes the butterfly output stream and emits each sample together with its matching packed twiddle coefficient (real high, imag low).
- Both outputs are time-aligned, so the multiplier can consume them combinationally.
- Tracks the sample index within the frame, derives the twiddle exponent for the configured stage, and looks it up in an elaboration-time ROM.

Parameters:
- NBITS, 16: width of each real/imag sample component (two's complement).
- NBITScoeff, 16: width of each real/imag coefficient component (two's complement).
- N, 128: FFT length; power of two, 4..1024.
- STAGE, 0: DIF stage index s, 0..log2(N)-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_sof  in  1  start of frame; qualified by in_valid; marks index 0.
- in_muestra  in  2*NBITS  sample, real [2*NBITS-1:NBITS], imag [NBITS-1:0].
- out_valid  out  1  output valid.
- out_muestra  out  2*NBITS  delayed sample, packed the same as in_muestra.
- out_coeff  out  2*NBITScoeff  twiddle, real [2*NBITScoeff-1:NBITScoeff], imag [NBITScoeff-1:0].
- out_sof  out  1  aligned start-of-frame flag.
- out_eof  out  1  aligned end-of-frame flag, high on index N-1.
- frame_err  out  1  one-cycle pulse when in_sof arrives at a nonzero index.

Behaviour:
- Reset: clk and reset are one clock domain; rst_n is asynchronous, active-low. All outputs and internal state clear to 0 on assertion. Release is synchronous to clk and needs no extra sequencing.
- Index counter cnt (log2(N) bits):
  - On an accepted sample (in_valid=1), the sample's index is 0 if in_sof=1, else cnt.
  - cnt then becomes that index+1, wrapping N-1 -> 0.
  - in_valid=0 is a bubble: cnt holds and nothing is emitted.
- Exponent rule, with L = N>>STAGE and p = index mod L:
  - p < L/2: e = 0 (W = 1).
  - p >= L/2: e = (p - L/2) << STAGE.
  - e is always in 0..N/2-1.
- ROM: N/2 entries, filled at elaboration with real-valued constant functions.
  - A = 2^(NBITScoeff-1)-1.
  - c_r = round(A*cos(2*pi*e/N)).
  - c_i = round(-A*sin(2*pi*e/N)).
  - Round half away from zero. Entries never reach -2^(NBITScoeff-1).
- Pipeline, fixed latency 2 cycles:
  - Stage 1 registers the sample, e, sof, eof (index==N-1), err and valid.
  - Stage 2 registers the ROM output and forwards the rest.
  - Input at edge k appears on the outputs after edge k+2.
  - No backpressure: every valid input produces exactly one output. Bubbles propagate as out_valid=0.
- out_muestra, out_coeff, out_sof, out_eof hold their last values while out_valid=0. out_sof, out_eof and frame_err are only meaningful when out_valid=1.
- frame_err:
  - Pulses when in_sof=1 with in_valid=1 and cnt != 0.
  - Aligned with the offending sample at the output (out_valid=1, out_sof=1).
  - The counter still restarts at 0 on that sample.
- in_sof with in_valid=0 is ignored.
- Reset mid-frame: in-flight samples are discarded and the counter restarts at 0. The first valid input after reset is index 0 even without in_sof.
- Simultaneous in_sof with wrap (cnt==0): a normal frame start, no error.

Optional Feature:
- FFT_TWIDDLE_CONJ_EN defined: the ROM stores the conjugate, c_i = round(+A*sin(2*pi*e/N)), for IFFT use. c_r is unchanged and latency is unchanged.
- Not defined: forward FFT twiddles as specified above.

Test Plan:
- Reset, then stream indices 0..127 with STAGE=0, sof on 0:
  - Idx 0..64 -> out_coeff=0x7FFF_0000.
  - Idx 80 -> 0x5A82_A57E.
  - Idx 96 -> 0x0000_8001.
  - out_eof on idx 127.
  - Each out_muestra equals its input 2 cycles earlier.
- STAGE=1: idx 32 -> 0x7FFF_0000; idx 48 -> 0x0000_8001 (e=32); idx 96 -> 0x7FFF_0000; idx 112 -> 0x0000_8001.
- Insert random in_valid=0 bubbles -> coefficient sequence identical to the gap-free run; out_valid mirrors in_valid delayed 2 cycles.
- in_sof at idx 50 -> frame_err pulse aligned with that sample; the next sample is index 1 (coeff 0x7FFF_0000 for STAGE=0).
- Assert rst_n low at idx 70 for 1 cycle -> all outputs 0 immediately; the next valid input is treated as index 0.
- Build with FFT_TWIDDLE_CONJ_EN, idx 96, STAGE=0 -> out_coeff=0x0000_7FFF.
